// File: rtl/cv32e40p_wb_arbiter.sv
// cv32e40p_wb_arbiter: per-source result FIFOs arbitrated onto one registered register-file write port
module cv32e40p_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  input  logic [NUM_SRC*ADDR_W-1:0] src_waddr_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata_i,
  input  logic [NUM_SRC-1:0]        src_nowb_i,
  input  logic                      wb_ready_i,
  input  logic                      flush_i,
  output logic                      rf_we_o,
  output logic [ADDR_W-1:0]         rf_waddr_o,
  output logic [DATA_W-1:0]         rf_wdata_o,
  output logic                      contention_o,
  input  logic                      perf_clr_i,
  output logic [31:0]               perf_cnt_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NUM_SRC);

  logic [PW-1:0]     rd_ptr [NUM_SRC];
  logic [PW-1:0]     wr_ptr [NUM_SRC];
  logic [CW-1:0]     cnt [NUM_SRC];
  logic [ADDR_W-1:0] mem_addr [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] mem_data [NUM_SRC][DEPTH];
  logic              mem_nowb [NUM_SRC][DEPTH];
  logic [ADDR_W-1:0] head_addr [NUM_SRC];
  logic [DATA_W-1:0] head_data [NUM_SRC];
  logic [NUM_SRC-1:0] push, pop, pending, skip;
  logic              gnt;
  logic [IW-1:0]     gnt_idx, rr_ptr, rr_idx;
  logic [31:0]       perf_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign head_addr[i]   = mem_addr[i][rd_ptr[i]];
    assign head_data[i]   = mem_data[i][rd_ptr[i]];
    assign skip[i]        = cnt[i] != '0 && mem_nowb[i][rd_ptr[i]];
    assign pending[i]     = cnt[i] != '0 && !mem_nowb[i][rd_ptr[i]];
    assign src_ready_o[i] = cnt[i] != CW'(DEPTH) && !flush_i;
    assign push[i]        = src_valid_i[i] && src_ready_o[i];
    assign pop[i]         = !flush_i && (skip[i] || (gnt && gnt_idx == IW'(i)));
    // storage writes at the tail; entries themselves need no reset
    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem_addr[i][wr_ptr[i]] <= src_waddr_i[i*ADDR_W +: ADDR_W];
        mem_data[i][wr_ptr[i]] <= src_wdata_i[i*DATA_W +: DATA_W];
        mem_nowb[i][wr_ptr[i]] <= src_nowb_i[i];
      end
    end
    // pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end else if (flush_i) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] == PW'(DEPTH - 1) ? '0 : wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] == PW'(DEPTH - 1) ? '0 : rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // source 0 wins outright; otherwise the first pending source after rr_ptr among 1..NUM_SRC-1
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    if (!flush_i && wb_ready_i) begin
      if (pending[0]) gnt = 1'b1;
      else
        for (int k = NUM_SRC - 1; k >= 1; k--) begin
          rr_idx = IW'((int'(rr_ptr) + k - 1) % (NUM_SRC - 1) + 1);
          if (pending[rr_idx]) begin
            gnt     = 1'b1;
            gnt_idx = rr_idx;
          end
        end
    end
  end

  assign contention_o = wb_ready_i && ($countones(pending) > 1);
  assign perf_cnt_o   = perf_cnt;

  // registered write port; address and data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= gnt;
      if (gnt) begin
        rf_waddr_o <= head_addr[gnt_idx];
        rf_wdata_o <= head_data[gnt_idx];
      end
    end
  end

  // round-robin pointer moves only on grants to the shared sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= IW'(NUM_SRC - 1);
    else if (gnt && gnt_idx != '0) rr_ptr <= gnt_idx;
  end

  // saturating contention counter, frozen during flush, clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt <= '0;
    else if (!flush_i) perf_cnt <= perf_clr_i ? '0 : (contention_o && perf_cnt != '1) ? perf_cnt + 1 : perf_cnt;
  end
endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// tb_cv32e40p_wb_arbiter: queue-based reference model with scoreboarded write-port monitor
module tb_cv32e40p_wb_arbiter;
  localparam int NS = 3, DEP = 2, AW = 6, DW = 32;

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic n;} ent_t;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  logic clk = 0, rst_n = 0;
  logic [NS-1:0] src_valid_i = '0, src_ready_o, src_nowb_i = '0;
  logic [NS*AW-1:0] src_waddr_i = '0;
  logic [NS*DW-1:0] src_wdata_i = '0;
  logic wb_ready_i = 0, flush_i = 0, perf_clr_i = 0;
  logic rf_we_o, contention_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [31:0] perf_cnt_o;

  ent_t mq[NS][$];
  wr_t wq[$];
  wr_t last = '0;
  int rr = NS - 1;
  logic [31:0] perf = '0;
  int tests = 0, fails = 0;

  cv32e40p_wb_arbiter #(.NUM_SRC(NS), .DEPTH(DEP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_waddr_i(src_waddr_i), .src_wdata_i(src_wdata_i), .src_nowb_i(src_nowb_i),
    .wb_ready_i(wb_ready_i), .flush_i(flush_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .contention_o(contention_o), .perf_clr_i(perf_clr_i),
    .perf_cnt_o(perf_cnt_o));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: each write must appear exactly one edge after the model's grant
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_we", rf_we_o, 0);
      chk("rst_waddr", rf_waddr_o, 0);
      chk("rst_wdata", rf_wdata_o, 0);
      chk("rst_perf", perf_cnt_o, 0);
      last = '0;
    end else begin
      chk("we", rf_we_o, wq.size() > 0);
      if (wq.size() > 0) last = wq.pop_front();
      chk("waddr", rf_waddr_o, last.a);
      chk("wdata", rf_wdata_o, last.d);
    end
  end

  task automatic put(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    src_waddr_i[i*AW +: AW] = a;
    src_wdata_i[i*DW +: DW] = d;
  endtask

  task automatic drv(logic [NS-1:0] v, logic [NS-1:0] n, logic w, logic f = 0, logic c = 0);
    src_valid_i = v;
    src_nowb_i  = n;
    wb_ready_i  = w;
    flush_i     = f;
    perf_clr_i  = c;
  endtask

  // one clock of the reference model; called at a falling edge with inputs already driven
  task automatic step();
    logic [NS-1:0] er, pend;
    int np, g;
    logic ec;
    #1;
    np = 0;
    for (int i = 0; i < NS; i++) begin
      er[i]   = mq[i].size() < DEP && !flush_i;
      pend[i] = mq[i].size() > 0 && !mq[i][0].n;
      np += int'(pend[i]);
    end
    ec = wb_ready_i && np >= 2;
    chk("ready", src_ready_o, er);
    chk("contention", contention_o, ec);
    chk("perf", perf_cnt_o, perf);
    g = -1;
    if (!flush_i && wb_ready_i) begin
      if (pend[0]) g = 0;
      else
        for (int k = 1; k < NS; k++) begin
          int idx = (rr - 1 + k) % (NS - 1) + 1;
          if (g < 0 && pend[idx]) g = idx;
        end
    end
    if (g >= 0) begin
      wq.push_back('{a: mq[g][0].a, d: mq[g][0].d});
      if (g > 0) rr = g;
    end
    if (!flush_i) perf = perf_clr_i ? 32'd0 : (ec && perf != 32'hFFFF_FFFF) ? perf + 1 : perf;
    for (int i = 0; i < NS; i++) begin
      if (flush_i) mq[i].delete();
      else begin
        if (g == i || (mq[i].size() > 0 && mq[i][0].n)) void'(mq[i].pop_front());
        if (src_valid_i[i] && er[i])
          mq[i].push_back('{a: src_waddr_i[i*AW +: AW], d: src_wdata_i[i*DW +: DW], n: src_nowb_i[i]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    drv('0, '0, 1);
    repeat (n) step();
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    drv('0, '0, 0);
    #1;
    chk("rst_ready", src_ready_o, {NS{1'b1}});
    chk("rst_contention", contention_o, 0);
    for (int i = 0; i < NS; i++) mq[i].delete();
    wq.delete();
    rr = NS - 1;
    perf = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // single write, two-cycle latency
    put(1, 6'd5, 32'hDEAD_BEEF);
    drv(3'b010, '0, 1);
    step();
    idle(4);
    // source 0 beats source 1 in the same cycle
    put(0, 6'd10, 32'h1111_0000);
    put(1, 6'd11, 32'h2222_0000);
    drv(3'b011, '0, 1);
    step();
    idle(4);
    // alternating round-robin between sources 1 and 2
    for (int j = 0; j < 8; j++) begin
      put(1, 6'(20 + j), 32'h1000 + j);
      put(2, 6'(40 + j), 32'h2000 + j);
      drv(3'b110, '0, 1);
      step();
    end
    idle(6);
    // no-writeback entry drains silently
    put(2, 6'd3, 32'hCAFE_F00D);
    drv(3'b100, 3'b100, 1);
    step();
    idle(3);
    // fill with write port stalled, then flush
    for (int j = 0; j < 3; j++) begin
      put(1, 6'(50 + j), 32'h5000 + j);
      drv(3'b010, '0, 0);
      step();
    end
    drv('0, '0, 0, 1);
    step();
    idle(3);
    // counter saturation and clear-over-increment
    for (int j = 0; j < 4; j++) begin
      put(1, 6'(j), $urandom);
      put(2, 6'(j + 8), $urandom);
      drv(3'b110, '0, 1);
      step();
    end
    force dut.perf_cnt = 32'hFFFF_FFFF;
    perf = 32'hFFFF_FFFF;
    step();
    release dut.perf_cnt;
    step();
    step();
    drv(3'b110, '0, 1, 0, 1);
    step();
    drv(3'b110, '0, 1);
    step();
    idle(6);
    // randomized traffic, mid-run reset, more traffic
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 400; j++) begin
        for (int i = 0; i < NS; i++) put(i, 6'($urandom), $urandom);
        drv(NS'($urandom), NS'($urandom) & NS'($urandom), ($urandom % 100) < 75,
            ($urandom % 100) < 3, ($urandom % 100) < 3);
        step();
      end
      if (r == 0) do_reset();
    end
    idle(10);
    chk("drained", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cv32e40p_wb_arbiter.md
CV32E40P_WB_ARBITER -- requirements
Module: cv32e40p_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, the number of result sources; legal range 2..8; source 0 is the LSU-class source.
REQ-002 SHALL have parameter DEPTH, default 2, the per-source result buffer depth; legal range 1..4.
REQ-003 SHALL have parameter ADDR_W, default 6, the register-file address width.
REQ-004 SHALL have parameter DATA_W, default 32, the write data width.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 src_valid_i  input  NUM_SRC  per-source result valid.
REQ-008 src_ready_o  output  NUM_SRC  per-source buffer not full.
REQ-009 src_waddr_i  input  NUM_SRC x ADDR_W  per-source destination register.
REQ-010 src_wdata_i  input  NUM_SRC x DATA_W  per-source result data.
REQ-011 src_nowb_i  input  NUM_SRC  result completes without a register write (e.g. FP load, vector op).
REQ-012 wb_ready_i  input  1  the register-file write port is available this cycle.
REQ-013 flush_i  input  1  discards all buffered results.
REQ-014 rf_we_o, rf_waddr_o, rf_wdata_o  output  1 / ADDR_W / DATA_W  registered write port.
REQ-015 contention_o  output  1  two or more writing heads are competing this cycle.
REQ-016 perf_clr_i  input  1  clears the contention counter.
REQ-017 perf_cnt_o  output  32  contention cycle counter.

Function
REQ-018 Each source SHALL own a FIFO of DEPTH entries holding {waddr, wdata, nowb}.
REQ-019 src_ready_o[i] SHALL be high when FIFO i is not full and flush_i is low; it SHALL NOT depend on a same-cycle pop.
REQ-020 An entry SHALL be enqueued when src_valid_i[i] and src_ready_o[i] are both high.
REQ-021 A pop SHALL only take an entry that was already present at the start of the cycle; there is no enqueue-to-pop bypass.
REQ-022 A head entry with nowb=1 SHALL pop unconditionally in the cycle it is at the head, SHALL NOT use the write port, and several such pops MAY occur in the same cycle.
REQ-023 Pending set = heads that are non-empty and have nowb=0; a grant SHALL occur only when wb_ready_i is high and the pending set is non-empty.
REQ-024 Source 0 SHALL have strict priority whenever it is pending.
REQ-025 Otherwise the grant SHALL go round-robin over sources 1..NUM_SRC-1, choosing the first pending source after rr_ptr and wrapping.
REQ-026 rr_ptr SHALL update to the granted index only on a grant to a source 1..NUM_SRC-1.
REQ-027 On a grant, the granted head SHALL pop, and on the next edge rf_we_o<=1 with that entry's waddr and wdata.
REQ-028 When there is no grant, rf_we_o SHALL be 0 on the next edge, and rf_waddr_o and rf_wdata_o SHALL hold their previous values.
REQ-029 Latency: an entry accepted in cycle 0 into an empty, uncontested FIFO with wb_ready_i high SHALL produce rf_we_o=1 in cycle 2.
REQ-030 contention_o SHALL be high (combinational) when the pending set has 2 or more members and wb_ready_i is high.
REQ-031 perf_cnt_o SHALL increment by 1 on each cycle with contention_o high and SHALL saturate at 0xFFFFFFFF.
REQ-032 perf_clr_i SHALL clear perf_cnt_o to 0 and SHALL take precedence over an increment in the same cycle.
REQ-033 With flush_i high, all FIFOs SHALL be empty on the next edge.
REQ-034 With flush_i high, rf_we_o SHALL be 0 on the next edge and no pop or grant SHALL occur.
REQ-035 With flush_i high, rr_ptr and perf_cnt_o SHALL be unchanged.
REQ-036 Pointer wrap-around at DEPTH SHALL be correct for any DEPTH in 1..4, including non-power-of-2 values.

Reset
REQ-037 While rst_n is low, all FIFOs SHALL be empty and rf_we_o=0.
REQ-038 While rst_n is low, rf_waddr_o=0, rf_wdata_o=0 and perf_cnt_o=0.
REQ-039 While rst_n is low, rr_ptr=NUM_SRC-1, so that source 1 wins the first round-robin grant.
REQ-040 While rst_n is low, src_ready_o SHALL be all ones; contention_o SHALL be 0, since the FIFOs are empty.
REQ-041 Reset asserted mid-operation SHALL discard all buffered entries, with no partial write.

Verification
REQ-042 Src1 valid, waddr=5, wdata=0xDEADBEEF in cycle 0, wb_ready=1 -> rf_we_o=1, waddr=5, wdata=0xDEADBEEF in cycle 2 only.
REQ-043 Src0 and src1 enqueue in the same cycle -> src0 written first, src1 one cycle later; contention_o=1 for one cycle; perf_cnt_o=1.
REQ-044 Src1 and src2 continuously valid, wb_ready=1 -> grants alternate 1,2,1,2 starting with src1.
REQ-045 Src2 valid with nowb=1, waddr=3 -> entry drains, rf_we_o never asserts, src_ready_o[2] stays high.
REQ-046 DEPTH=2, wb_ready=0, src1 sends 3 results -> src_ready_o[1]=0 after 2 accepts; flush_i pulse -> FIFO empty, src_ready_o[1]=1, rf_we_o=0.
REQ-047 Counter preloaded to 0xFFFFFFFF with contention ongoing -> stays at 0xFFFFFFFF; perf_clr_i plus contention in the same cycle -> 0.
